hfifo_pf: RTL and testbench

//  Parametrised successor to the basic handshake FIFO: single-clock FIFO that adds a fill

---
 rtl/hfifo_pkg.sv | 12 +
 rtl/hfifo_ram.sv | 22 ++
 rtl/hfifo_pf.sv | 125 ++++++++++++
 tb/tb_hfifo_pf.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hfifo_pkg.sv
// Shared sizing helpers and parameter sanity checks for the hfifo_pf FIFO.
package hfifo_pkg;

   function automatic int unsigned lvl_w(input int unsigned size);
      return $clog2(size) + 1;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/hfifo_ram.sv
// FIFO storage: synchronous write port, asynchronous read port.
module hfifo_ram #(
   parameter int unsigned SIZE   = 256,
   parameter int unsigned DWIDTH = 8
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [$clog2(SIZE)-1:0] waddr,
   input  logic [DWIDTH-1:0]       wdata,
   input  logic [$clog2(SIZE)-1:0] raddr,
   output logic [DWIDTH-1:0]       rdata
);

   logic [DWIDTH-1:0] mem [SIZE];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hfifo_pf.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, flush and sticky errors.
module hfifo_pf
   import hfifo_pkg::*;
#(
   parameter int unsigned SIZE      = 256,
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned AF_THRESH = SIZE - 2,
   parameter int unsigned AE_THRESH = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DWIDTH-1:0]         din,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic                      clr_err,
   output logic [DWIDTH-1:0]         dout,
   output logic                      rdy,
   output logic                      not_full,
   output logic [lvl_w(SIZE)-1:0]    level,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned AW = $clog2(SIZE);
   localparam int unsigned LW = lvl_w(SIZE);

   if (!is_pow2(SIZE) || SIZE < 2) begin : g_bad_size
      $error("hfifo_pf: SIZE must be a power of 2 and >= 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > SIZE) begin : g_bad_af
      $error("hfifo_pf: AF_THRESH must be in 1..SIZE");
   end
   if (AE_THRESH >= SIZE) begin : g_bad_ae
      $error("hfifo_pf: AE_THRESH must be < SIZE");
   end

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          rdy_q, rdy_d;
   logic          not_full_q, not_full_d;
   logic          almost_full_q, almost_full_d;
   logic          almost_empty_q, almost_empty_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          pop_acc, push_acc, wr_en;

   always_comb begin
      pop_acc  = pop & (level_q != '0);
      push_acc = push & ((level_q != LW'(SIZE)) | pop_acc);
      wr_en    = push_acc & ~flush;

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q & ~clr_err;
      underflow_d = underflow_q & ~clr_err;

      // Flush discards same-cycle traffic entirely, so refused requests are not errors.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
         level_d     = level_q + LW'(push_acc) - LW'(pop_acc);
         overflow_d  = overflow_d | (push & ~push_acc);
         underflow_d = underflow_d | (pop & ~pop_acc);
      end

      rdy_d          = (level_d != '0);
      not_full_d     = (level_d != LW'(SIZE));
      almost_full_d  = (level_d >= LW'(AF_THRESH));
      almost_empty_d = (level_d <= LW'(AE_THRESH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         rdy_q          <= 1'b0;
         not_full_q     <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         rdy_q          <= rdy_d;
         not_full_q     <= not_full_d;
         almost_full_q  <= almost_full_d;
         almost_empty_q <= almost_empty_d;
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   hfifo_ram #(
      .SIZE   (SIZE),
      .DWIDTH (DWIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

   assign rdy          = rdy_q;
   assign not_full     = not_full_q;
   assign level        = level_q;
   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_hfifo_pf.sv
// Directed scoreboard bench for hfifo_pf at SIZE=8, DWIDTH=8, AF_THRESH=6, AE_THRESH=1.
module tb_hfifo_pf;

   localparam int unsigned SIZE = 8;
   localparam int unsigned AF   = 6;
   localparam int unsigned AE   = 1;

   logic       clk = 1'b0;
   logic       reset, push, pop, flush, clr_err;
   logic [7:0] din, dout;
   logic       rdy, not_full, almost_full, almost_empty, overflow, underflow;
   logic [3:0] level;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [7:0] sb[$];
   bit         m_ovf, m_unf;

   always #5 clk = ~clk;

   hfifo_pf #(
      .SIZE      (SIZE),
      .DWIDTH    (8),
      .AF_THRESH (AF),
      .AE_THRESH (AE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .din          (din),
      .push         (push),
      .pop          (pop),
      .flush        (flush),
      .clr_err      (clr_err),
      .dout         (dout),
      .rdy          (rdy),
      .not_full     (not_full),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_state();
      int unsigned n;
      n = sb.size();
      check("level", 32'(level), 32'(n));
      check("rdy", 32'(rdy), 32'(n != 0));
      check("not_full", 32'(not_full), 32'(n != SIZE));
      check("almost_full", 32'(almost_full), 32'(n >= AF));
      check("almost_empty", 32'(almost_empty), 32'(n <= AE));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      if (n != 0) check("dout", 32'(dout), 32'(sb[0]));
   endtask

   // One clock: drive requests, advance the reference model, then compare after the edge.
   task automatic cyc(input bit ps, input logic [7:0] d, input bit pp,
                      input bit fl = 1'b0, input bit ce = 1'b0);
      bit pa, ua;
      push = ps; din = d; pop = pp; flush = fl; clr_err = ce;
      m_ovf = m_ovf && !ce;
      m_unf = m_unf && !ce;
      if (fl) begin
         sb.delete();
      end else begin
         pa = pp && (sb.size() > 0);
         ua = ps && ((sb.size() < SIZE) || pa);
         if (pa) void'(sb.pop_front());
         if (ua) sb.push_back(d);
         if (ps && !ua) m_ovf = 1'b1;
         if (pp && !pa) m_unf = 1'b1;
      end
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
      check_state();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_state();
   endtask

   initial begin
      reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
      m_ovf = 1'b0; m_unf = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Fill: level 1..8 with threshold transitions along the way
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0);
      check("full_level", 32'(level), 32'd8);
      check("full_not_full", 32'(not_full), 32'd0);

      // Overflow on push while full, then drain in order
      cyc(1'b1, 8'h99, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // Full with simultaneous push+pop keeps level at 8
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0);
      cyc(1'b1, 8'hAA, 1'b1);
      check("full_pp_level", 32'(level), 32'd8);
      check("full_pp_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);

      // Underflow, then empty push+pop: push wins, pop is an error
      cyc(1'b0, 8'h00, 1'b1);
      check("unf_set", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 8'h55, 1'b1);
      check("empty_pp_level", 32'(level), 32'd1);
      check("empty_pp_unf", 32'(underflow), 32'd1);
      check("empty_pp_dout", 32'(dout), 32'h55);
      // clr_err together with a fresh underflow keeps the flag set
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check("clr_vs_new_err", 32'(underflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Flush at level 5 with a same-cycle push
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
      cyc(1'b1, 8'h77, 1'b1, 1'b1);
      check("flush_level", 32'(level), 32'd0);
      check("flush_rdy", 32'(rdy), 32'd0);
      check("flush_no_err", 32'({overflow, underflow}), 32'd0);
      cyc(1'b1, 8'h01, 1'b0);
      check("post_flush_dout", 32'(dout), 32'h01);
      cyc(1'b0, 8'h00, 1'b1);

      // Steady traffic at level 3 wrapping the pointers
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      check("wrap_level", 32'(level), 32'd3);
      cyc(1'b1, 8'hE1, 1'b0);
      check("pre_reset_level", 32'(level), 32'd4);
      do_reset();
      check("rst_not_full", 32'(not_full), 32'd1);
      cyc(1'b1, 8'h42, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
